// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode encodings, per-mode register length and feedback tap,
// plus helpers for masking and zero-seed protection.
package prbs_pkg;

  localparam int unsigned MAX_LEN = 31;

  typedef enum logic [2:0] {
    ModePrbs7  = 3'd0,
    ModePrbs9  = 3'd1,
    ModePrbs15 = 3'd2,
    ModePrbs23 = 3'd3,
    ModePrbs31 = 3'd4
  } prbs_mode_e;

  function automatic logic mode_is_valid(logic [2:0] mode);
    return mode <= 3'd4;
  endfunction

  // Reserved encodings fall back to PRBS9.
  function automatic prbs_mode_e mode_sanitize(logic [2:0] mode);
    return mode_is_valid(mode) ? prbs_mode_e'(mode) : ModePrbs9;
  endfunction

  function automatic logic [4:0] mode_len(prbs_mode_e mode);
    case (mode)
      ModePrbs7:  return 5'd7;
      ModePrbs15: return 5'd15;
      ModePrbs23: return 5'd23;
      ModePrbs31: return 5'd31;
      default:    return 5'd9;
    endcase
  endfunction

  function automatic logic [4:0] mode_tap(prbs_mode_e mode);
    case (mode)
      ModePrbs7:  return 5'd6;
      ModePrbs15: return 5'd14;
      ModePrbs23: return 5'd18;
      ModePrbs31: return 5'd28;
      default:    return 5'd5;
    endcase
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(logic [4:0] len);
    return (31'd1 << len) - 31'd1;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes all ones.
  function automatic logic [MAX_LEN-1:0] seed_init(logic [4:0] len, logic [MAX_LEN-1:0] seed);
    logic [MAX_LEN-1:0] masked;
    masked = seed & len_mask(len);
    return (masked == '0) ? len_mask(len) : masked;
  endfunction

endpackage

// File: rtl/prbs_gen_par_if.sv
// Valid/ready word stream carrying PRBS output words.
interface prbs_gen_par_if #(
  parameter int unsigned NW = 8
);
  logic [NW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational unroll of NW Fibonacci LFSR steps; word_o[NW-1] is the earliest bit.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int unsigned NW = 8
) (
  input  logic [MAX_LEN-1:0] state_i,
  input  logic [4:0]         len_i,
  input  logic [4:0]         tap_i,
  output logic [NW-1:0]      word_o,
  output logic [MAX_LEN-1:0] state_o
);

  logic [MAX_LEN-1:0] s;
  logic [MAX_LEN-1:0] mask;
  logic               msb;
  logic               fb;

  always_comb begin
    mask   = len_mask(len_i);
    s      = state_i;
    msb    = 1'b0;
    fb     = 1'b0;
    word_o = '0;
    for (int k = 0; k < NW; k++) begin
      msb = s[len_i - 5'd1];
      fb  = msb ^ s[tap_i - 5'd1];
      word_o[NW-1-k] = msb;
      s = {s[MAX_LEN-2:0], fb} & mask;
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_gen_par.sv
// Parallel runtime-selectable PRBS generator, NW bits per word behind a valid/ready stage.
// Define PRBS_ERR_INJ_EN to add i_err_inj, which inverts the MSB of a loaded word.
module prbs_gen_par
  import prbs_pkg::*;
#(
  parameter int unsigned NW       = 8,
  parameter logic [2:0]  RST_MODE = 3'd1,
  parameter logic [30:0] SEED     = 31'h1AA
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_seed_load,
  input  logic [2:0]    i_mode,
  input  logic [30:0]   i_seed,
`ifdef PRBS_ERR_INJ_EN
  input  logic          i_err_inj,
`endif
  prbs_gen_par_if.master out_if,
  output logic          o_seed_fix,
  output logic          o_mode_err
);

  localparam prbs_mode_e         RstMode  = mode_sanitize(RST_MODE);
  localparam logic [MAX_LEN-1:0] RstState = seed_init(mode_len(RstMode), SEED);

  prbs_mode_e         mode_q, mode_d;
  logic [MAX_LEN-1:0] state_q, state_d;
  logic [NW-1:0]      data_q, data_d;
  logic               valid_q, valid_d;
  logic               seed_fix_q, seed_fix_d;
  logic               mode_err_q, mode_err_d;

  logic [NW-1:0]      step_word;
  logic [MAX_LEN-1:0] step_state;
  logic [NW-1:0]      load_word;
  logic [4:0]         new_len;
  logic               load;

  prbs_lfsr_step #(
    .NW (NW)
  ) u_step (
    .state_i (state_q),
    .len_i   (mode_len(mode_q)),
    .tap_i   (mode_tap(mode_q)),
    .word_o  (step_word),
    .state_o (step_state)
  );

  assign load = i_enable && (!valid_q || out_if.ready);

`ifdef PRBS_ERR_INJ_EN
  assign load_word = {step_word[NW-1] ^ i_err_inj, step_word[NW-2:0]};
`else
  assign load_word = step_word;
`endif

  assign new_len = mode_len(mode_sanitize(i_mode));

  always_comb begin
    mode_d     = mode_q;
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    seed_fix_d = 1'b0;
    mode_err_d = 1'b0;
    if (i_seed_load) begin
      // Any word still held in o_data is dropped here.
      mode_d     = mode_sanitize(i_mode);
      mode_err_d = !mode_is_valid(i_mode);
      state_d    = seed_init(new_len, i_seed);
      seed_fix_d = (i_seed & len_mask(new_len)) == '0;
      valid_d    = 1'b0;
    end else if (load) begin
      data_d  = load_word;
      valid_d = 1'b1;
      state_d = step_state;
    end else if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q     <= RstMode;
      state_q    <= RstState;
      data_q     <= '0;
      valid_q    <= 1'b0;
      seed_fix_q <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      seed_fix_q <= seed_fix_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign o_seed_fix   = seed_fix_q;
  assign o_mode_err   = mode_err_q;

endmodule

// File: doc/prbs_gen_par.md
# prbs_gen_par

Parallel, runtime-selectable PRBS generator producing NW bits per clock behind a valid/ready output stage. Supports PRBS7/9/15/23/31, loadable seed, all-zero seed protection and optional error injection. Successor to the single-bit fixed-polynomial PRBS source, intended to drive the serializer/test-pattern path and the matching checker at word rate.

## Interface
- NW, 8: output bits per word (1..32).
- RST_MODE, 3'd1: polynomial mode after reset (encoding below).
- SEED, 31'h1AA: reset seed, masked to the active length L.
- clock  in  1: rising-edge clock.
- i_reset  in  1: reset, synchronous, active-high; clock clock.
- i_enable  in  1: allows generation of new words.
- i_seed_load  in  1: one-cycle strobe; latches i_mode and i_seed.
- i_mode  in  3: 0 PRBS7 (x^7+x^6+1), 1 PRBS9 (x^9+x^5+1), 2 PRBS15 (x^15+x^14+1), 3 PRBS23 (x^23+x^18+1), 4 PRBS31 (x^31+x^28+1); 5..7 reserved.
- i_seed  in  31: seed; bits above L-1 ignored.
- i_ready  in  1: downstream accepts o_data.
- o_data  out  NW: word; o_data[NW-1] is earliest bit in time.
- o_valid  out  1: o_data valid.
- o_seed_fix  out  1: one-cycle pulse, zero seed replaced.
- o_mode_err  out  1: one-cycle pulse, reserved mode loaded.

## Operation
- State s[30:0], active length L, tap T from mode. Single step: output bit b = s[L-1]; s[L-1:0] <= {s[L-2:0], s[L-1]^s[T-1]}; bits ≥ L held at 0.
- Word = NW consecutive steps: o_data[NW-1-k] = b_k, k = 0..NW-1; state advances NW steps per loaded word.
- Load condition: i_enable && (!o_valid || i_ready). On load: o_data <= next word, o_valid <= 1, state advances.
- o_valid && i_ready && !load condition: o_valid <= 0. o_valid && !i_ready: o_data, o_valid, state held (stall).
- Seed load: mode register <= i_mode; state <= i_seed masked to L; o_valid <= 0; no word generated that cycle. Masked seed zero: state <= all ones in L bits, o_seed_fix = 1 next cycle. Reserved mode: mode <= PRBS9, o_mode_err = 1 next cycle, seed handled with L = 9.
- Priority: i_reset > i_seed_load > load/handshake. A word held in o_data during seed load is discarded.
- Reset values: state = SEED masked to L(RST_MODE) (zero → all ones), mode = RST_MODE, o_data = 0, o_valid = 0, o_seed_fix = 0, o_mode_err = 0.

## Timing
- Latency: first enabled cycle after reset/seed load → o_valid high next cycle.
- Throughput: one word per clock while i_enable && i_ready.
- Reset or seed load mid-stream: o_valid low the following cycle; sequence restarts from the new seed.
- o_data changes only on load cycles; stable throughout any stall.
- Full period (2^L-1 bits) returns state to seed after (2^L-1)·NW/gcd(NW,2^L-1) bits.

## Configuration
- PRBS_ERR_INJ_EN defined: adds port i_err_inj (in, 1). If high on a load cycle, o_data[NW-1] of the loaded word is inverted; LFSR state unaffected; ignored on non-load cycles.
- Not defined: port absent, output always the pure sequence.

## Structure
- Package prbs_pkg: mode encodings, per-mode L and T constants, MAX_LEN = 31, mode typedef.
- Sub-module prbs_lfsr_step: combinational NW-step unroll (inputs state, L, T; outputs word and next state). Top holds registers, handshake and seed/mode control.

## Test plan
- NW=8, seed load mode 0 seed 7'h7F, enable, ready → words 0xFE, 0x04, ...; word 127 equals 0xFE again.
- Reset with defaults, mode PRBS9 seed 9'h1AA, enable one cycle → o_valid next cycle, o_data = 0xD5 (SEED[8:1]).
- Stall: i_ready low 5 cycles with o_valid high → o_data unchanged, state unchanged; release → next word exactly follows held word.
- Seed load with i_seed = 0, mode 2 → o_seed_fix pulse, first word 0xFF.
- Seed load mode 6 → o_mode_err pulse, output matches PRBS9 from given seed; seed load coincident with handshake → held word dropped, o_valid low one cycle.
- PRBS_ERR_INJ_EN: i_err_inj on second load → that word MSB inverted only; following words match golden model.
